// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: one-stage branch/jump resolver with redirect target and squash window.
// Ports: clk, reset (sync, active-high); in_valid/in_ready handshake; opcode, rs1_val,
// rs2_val, pc, offset inputs; branch, jump, redirect, target, flush outputs;
// taken_cnt, resolved_cnt statistics (live only when BRU_STATS_EN is defined, else 0).
module branch_resolve_unit #(
  parameter int XLEN          = 32,
  parameter int OPW           = 6,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNTW          = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  opcode,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  output logic            branch,
  output logic            jump,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            flush,
  output logic [CNTW-1:0] taken_cnt,
  output logic [CNTW-1:0] resolved_cnt
);

  localparam logic [OPW-1:0] OP_JUMP = OPW'(6'h15);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h16);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'h17);
  localparam logic [OPW-1:0] OP_BLT  = OPW'(6'h18);
  localparam logic [OPW-1:0] OP_BGE  = OPW'(6'h19);

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);
  localparam bit         SQ_EN   = (SQUASH_CYCLES != 0);

  typedef enum logic {
    RUN,
    SQUASH
  } state_t;

  state_t      state;
  logic [3:0]  sq_cnt;

  logic            accept;
  logic            is_jump;
  logic            is_br;
  logic            cond;
  logic            taken;
  logic            ctrl;
  logic            op_eq;
  logic            op_lt;
  logic [XLEN-1:0] tgt_sum;

  assign in_ready = (state == RUN);
  assign flush    = (state == SQUASH);
  assign accept   = in_valid && in_ready;

  assign op_eq   = (rs1_val == rs2_val);
  assign op_lt   = ($signed(rs1_val) < $signed(rs2_val));
  assign tgt_sum = pc + offset;

  always_comb begin
    is_jump = 1'b0;
    is_br   = 1'b0;
    cond    = 1'b0;
    unique case (1'b1)
      (opcode == OP_JUMP): is_jump = 1'b1;
      (opcode == OP_BEQ): begin
        is_br = 1'b1;
        cond  = op_eq;
      end
      (opcode == OP_BNE): begin
        is_br = 1'b1;
        cond  = !op_eq;
      end
      (opcode == OP_BLT): begin
        is_br = 1'b1;
        cond  = op_lt;
      end
      (opcode == OP_BGE): begin
        is_br = 1'b1;
        cond  = !op_lt;
      end
      default: ;
    endcase
  end

  assign taken = is_jump || (is_br && cond);
  assign ctrl  = is_jump || is_br;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      sq_cnt   <= '0;
      branch   <= 1'b0;
      jump     <= 1'b0;
      redirect <= 1'b0;
      target   <= '0;
    end else begin
      branch   <= accept && is_br && cond;
      jump     <= accept && is_jump;
      redirect <= accept && taken;
      if (accept && taken) begin
        target <= tgt_sum;
      end
      unique case (state)
        RUN: begin
          if (accept && taken && SQ_EN) begin
            state  <= SQUASH;
            sq_cnt <= SQ_LOAD;
          end
        end
        SQUASH: begin
          // sq_cnt==1 marks the last flush cycle
          sq_cnt <= sq_cnt - 4'd1;
          if (sq_cnt == 4'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state  <= RUN;
          sq_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BRU_STATS_EN
  logic [CNTW-1:0] taken_q;
  logic [CNTW-1:0] resolved_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q    <= '0;
      resolved_q <= '0;
    end else begin
      if (accept && ctrl) begin
        resolved_q <= resolved_q + CNTW'(1);
      end
      if (accept && taken) begin
        taken_q <= taken_q + CNTW'(1);
      end
    end
  end

  assign taken_cnt    = taken_q;
  assign resolved_cnt = resolved_q;
`else
  logic unused_ctrl;
  assign unused_ctrl  = ctrl;
  assign taken_cnt    = '0;
  assign resolved_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench for branch_resolve_unit.
// Expected outputs are queued at drive time and popped after the clock edge.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int OPW  = 6;
  localparam int SQ   = 2;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  opcode;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] offset;
  logic            branch;
  logic            jump;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            flush;
  logic [CNTW-1:0] taken_cnt;
  logic [CNTW-1:0] resolved_cnt;

  branch_resolve_unit #(
    .XLEN(XLEN),
    .OPW(OPW),
    .SQUASH_CYCLES(SQ),
    .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opcode(opcode),
    .rs1_val(rs1_val),
    .rs2_val(rs2_val),
    .pc(pc),
    .offset(offset),
    .branch(branch),
    .jump(jump),
    .redirect(redirect),
    .target(target),
    .flush(flush),
    .taken_cnt(taken_cnt),
    .resolved_cnt(resolved_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            br;
    logic            jp;
    logic            rd;
    logic            fl;
    logic [XLEN-1:0] tgt;
    logic [CNTW-1:0] tc;
    logic [CNTW-1:0] rc;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  int              m_sq  = 0;
  logic [XLEN-1:0] m_tgt = '0;
  logic [CNTW-1:0] m_tc  = '0;
  logic [CNTW-1:0] m_rc  = '0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // called just after a rising edge; ends just after the next one
  task automatic cycle(input bit rst, input bit v, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] o);
    exp_t e;
    exp_t g;
    bit   rdy;
    bit   acc;
    bit   isj;
    bit   isb;
    bit   cnd;
    bit   lt;
    bit   tk;
    reset    = rst;
    in_valid = v;
    opcode   = op;
    rs1_val  = a;
    rs2_val  = b;
    pc       = p;
    offset   = o;
    rdy = (m_sq == 0);
    #1;
    check("in_ready", in_ready, rdy);
    isj = 0;
    isb = 0;
    cnd = 0;
    lt  = (a[31] != b[31]) ? a[31] : (a < b);
    case (op)
      6'h15: isj = 1;
      6'h16: begin isb = 1; cnd = (a == b); end
      6'h17: begin isb = 1; cnd = (a != b); end
      6'h18: begin isb = 1; cnd = lt; end
      6'h19: begin isb = 1; cnd = !lt; end
      default: ;
    endcase
    acc = v && rdy;
    tk  = acc && (isj || (isb && cnd));
    if (rst) begin
      m_sq  = 0;
      m_tgt = '0;
      m_tc  = '0;
      m_rc  = '0;
      e.br  = 0;
      e.jp  = 0;
      e.rd  = 0;
    end else begin
      e.br = acc && isb && cnd;
      e.jp = acc && isj;
      e.rd = tk;
      if (tk) m_tgt = p + o;
      if (acc && (isj || isb)) m_rc = m_rc + 1'b1;
      if (tk) m_tc = m_tc + 1'b1;
      if (tk) m_sq = SQ;
      else if (m_sq > 0) m_sq = m_sq - 1;
    end
    e.fl  = (m_sq > 0);
    e.tgt = m_tgt;
`ifdef BRU_STATS_EN
    e.tc = m_tc;
    e.rc = m_rc;
`else
    e.tc = '0;
    e.rc = '0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty want entry");
    end else begin
      g = sbq.pop_front();
      check("branch", branch, g.br);
      check("jump", jump, g.jp);
      check("redirect", redirect, g.rd);
      check("flush", flush, g.fl);
      check("target", target, g.tgt);
      check("taken_cnt", taken_cnt, g.tc);
      check("resolved_cnt", resolved_cnt, g.rc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 6'h00, 0, 0, 0, 0);
  endtask

  initial begin
    logic [5:0]  ops [7];
    logic [5:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    ops[0] = 6'h15;
    ops[1] = 6'h16;
    ops[2] = 6'h17;
    ops[3] = 6'h18;
    ops[4] = 6'h19;
    ops[5] = 6'h00;
    ops[6] = 6'h3f;
    reset    = 1;
    in_valid = 0;
    opcode   = '0;
    rs1_val  = '0;
    rs2_val  = '0;
    pc       = '0;
    offset   = '0;
    @(posedge clk);
    #1;
    cycle(1, 0, 6'h00, 0, 0, 0, 0);
    cycle(1, 0, 6'h00, 0, 0, 0, 0);
    idle(1);
    // taken BEQ then squash window
    cycle(0, 1, 6'h16, 32'h1234, 32'h1234, 32'h100, 32'h20);
    idle(3);
    // BLT taken, BGE not taken, then an instruction right behind
    cycle(0, 1, 6'h18, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40);
    idle(2);
    cycle(0, 1, 6'h19, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40);
    cycle(0, 1, 6'h00, 32'h5, 32'h6, 32'h304, 32'h8);
    idle(1);
    // jump with wrap-around target
    cycle(0, 1, 6'h15, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20);
    idle(3);
    // four not-taken BNE back to back, counted from a fresh reset
    cycle(1, 0, 6'h00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 6'h17, 32'h77, 32'h77, 32'h400 + 4 * i, 32'h10);
    idle(1);
    // JUMP offered during squash must be ignored
    cycle(1, 0, 6'h00, 0, 0, 0, 0);
    cycle(0, 1, 6'h16, 32'h9, 32'h9, 32'h500, 32'h100);
    cycle(0, 1, 6'h15, 0, 0, 32'h504, 32'h800);
    cycle(0, 1, 6'h15, 0, 0, 32'h504, 32'h800);
    idle(2);
    // reset in the first squash cycle
    cycle(0, 1, 6'h16, 32'h1, 32'h1, 32'h600, 32'h30);
    cycle(1, 1, 6'h15, 0, 0, 32'h604, 32'h10);
    idle(2);
    // mixed traffic
    for (int i = 0; i < 60; i++) begin
      rop = ops[$urandom_range(0, 6)];
      ra  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 2)
                                        : 32'($urandom_range(0, 2));
      rb  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 2)
                                        : 32'($urandom_range(0, 2));
      cycle(0, $urandom_range(0, 3) != 0, rop, ra, rb, $urandom, $urandom);
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
